// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the memory_game session sequencer.
// Holds the session FSM state encoding, the default score width and the
// WAIT_END guard limit used by game_session_ctrl.

package game_pkg;

  // Session sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_ARM      = 3'd2,
    ST_PLAY     = 3'd3,
    ST_WAIT_END = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Score width produced by the memory_game core
  localparam int SCORE_W_DEF = 4;

  // Width and terminal value of the WAIT_END guard counter
  localparam int             GUARD_W     = 3;
  localparam logic [GUARD_W-1:0] GUARD_LIMIT = 3'd7;

endpackage : game_pkg

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: one-second prescaler for the session countdown.
// Counts 0..CLK_HZ-1 while hold is low and emits a single-cycle tick on the
// terminal count, then wraps to 0. hold freezes the count in place so that
// counting resumes from the same value; clear forces the count back to 0.

module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  // The tick is only seen when the prescaler is actually advancing
  assign tick = !hold && (count == LAST);

  // Prescaler register: clear wins over hold, wrap on the terminal count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!hold) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule : sec_tick_gen

// File: rtl/game_session_ctrl.sv
// game_session_ctrl: session sequencer sitting between the board I/O and the
// memory_game core. Converts the player button into single-cycle pulses,
// clears the core at session start, runs the countdown, raises the core's
// game timeout, and captures the last and best scores.
// Optional feature: define PAUSE_ACTIVE_EN to let the pause input freeze the
// session while in PLAY; without it the pause input is ignored.

module game_session_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SESSION_SEC = 60,
  parameter int TIME_W      = 7,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  input  logic               pause,
  input  logic [SCORE_W-1:0] core_score,
  input  logic               core_end_game,
  output logic               core_enable,
  output logic               core_bIn,
  output logic               core_rst_n,
  output logic               game_timeout,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] last_score,
  output logic [SCORE_W-1:0] best_score,
  output logic               session_active
);

  state_t               state;
  state_t               state_nxt;
  logic                 btn_q;
  logic                 btn_pulse;
  logic                 paused;
  logic                 tick;
  logic                 presc_clear;
  logic                 presc_hold;
  logic                 session_end;
  logic [GUARD_W-1:0]   guard;

  // Rising edge of the (already debounced) button; a held button pulses once
  assign btn_pulse = btn_raw & ~btn_q;

`ifdef PAUSE_ACTIVE_EN
  // Pause only has an effect while the round is being played
  assign paused = pause && (state == ST_PLAY);
`else
  // Pause port is present for pin compatibility but never takes effect
  assign paused = pause & 1'b0;
`endif

  // Prescaler restarts from 0 at session start and only runs in unpaused PLAY
  assign presc_clear = (state == ST_CLEAR);
  assign presc_hold  = (state != ST_PLAY) || paused;

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .hold  (presc_hold),
    .tick  (tick)
  );

  // The core is held in reset during our reset and for the single CLEAR cycle
  assign core_rst_n = !rst && (state != ST_CLEAR);

  // A session ends when WAIT_END sees the core finish or the guard runs out
  assign session_end = (state == ST_WAIT_END) &&
                       (core_end_game || (guard == GUARD_LIMIT));

  // Next-state and core-facing outputs; a core-reported end beats a timeout
  always_comb begin
    state_nxt      = state;
    core_enable    = 1'b0;
    core_bIn       = 1'b0;
    game_timeout   = 1'b0;
    session_active = 1'b0;

    case (state)
      ST_IDLE: begin
        if (btn_pulse) begin
          state_nxt = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        state_nxt = ST_ARM;
      end

      ST_ARM: begin
        core_enable    = 1'b1;
        core_bIn       = 1'b1;
        session_active = 1'b1;
        state_nxt      = ST_PLAY;
      end

      ST_PLAY: begin
        core_enable    = !paused;
        core_bIn       = btn_pulse && !paused;
        session_active = 1'b1;
        if (core_end_game) begin
          state_nxt = ST_WAIT_END;
        end else if (tick && (time_left == TIME_W'(1))) begin
          game_timeout = 1'b1;
          state_nxt    = ST_WAIT_END;
        end
      end

      ST_WAIT_END: begin
        core_enable    = 1'b1;
        session_active = 1'b1;
        if (session_end) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        if (btn_pulse) begin
          state_nxt = ST_CLEAR;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (rst) begin
      core_enable    = 1'b0;
      core_bIn       = 1'b0;
      game_timeout   = 1'b0;
      session_active = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Previous button level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_raw;
    end
  end

  // Countdown: loaded at session start, decremented on each second tick in PLAY
  always_ff @(posedge clk) begin
    if (rst) begin
      time_left <= '0;
    end else if (state == ST_CLEAR) begin
      time_left <= TIME_W'(SESSION_SEC);
    end else if ((state == ST_PLAY) && tick) begin
      time_left <= time_left - TIME_W'(1);
    end
  end

  // WAIT_END guard: restarts every time the state is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      guard <= '0;
    end else if (state == ST_WAIT_END) begin
      guard <= guard + GUARD_W'(1);
    end else begin
      guard <= '0;
    end
  end

  // Score capture on session end; best score is an unsigned running maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      last_score <= '0;
      best_score <= '0;
    end else if (session_end) begin
      last_score <= core_score;
      if (core_score > best_score) begin
        best_score <= core_score;
      end
    end
  end

endmodule : game_session_ctrl

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: self-checking bench for game_session_ctrl with
// CLK_HZ=4 and SESSION_SEC=3. A session-level reference model (phase plus
// counts of unpaused play cycles and wait cycles) predicts every output each
// cycle; directed sessions are followed by randomized traffic.

module tb_game_session_ctrl;

  localparam int CLK_HZ      = 4;
  localparam int SESSION_SEC = 3;
  localparam int TIME_W      = 7;
  localparam int SCORE_W     = 4;
  localparam int WAIT_MAX    = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               btn_raw;
  logic               pause;
  logic [SCORE_W-1:0] core_score;
  logic               core_end_game;
  logic               core_enable;
  logic               core_bIn;
  logic               core_rst_n;
  logic               game_timeout;
  logic [TIME_W-1:0]  time_left;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] best_score;
  logic               session_active;

  always #5 clk = ~clk;

  game_session_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .SESSION_SEC (SESSION_SEC),
    .TIME_W      (TIME_W),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_raw        (btn_raw),
    .pause          (pause),
    .core_score     (core_score),
    .core_end_game  (core_end_game),
    .core_enable    (core_enable),
    .core_bIn       (core_bIn),
    .core_rst_n     (core_rst_n),
    .game_timeout   (game_timeout),
    .time_left      (time_left),
    .last_score     (last_score),
    .best_score     (best_score),
    .session_active (session_active)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: session phase plus plain counters
  typedef enum {M_IDLE, M_CLEAR, M_ARM, M_PLAY, M_WAIT, M_DONE} mphase_t;
  mphase_t mPhase     = M_IDLE;
  bit      mBtnPrev   = 1'b0;
  bit      mTimeValid = 1'b0;
  int      mActive    = 0;
  int      mWait      = 0;
  int      mLast      = 0;
  int      mBest      = 0;
  bit      prevTimeout = 1'b0;

  // Compare one observed value against the model and count it
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive all DUT inputs for the coming cycle
  task automatic applyStimulus(input logic r, input logic b, input logic p,
                               input logic e, input logic [SCORE_W-1:0] s);
    rst           = r;
    btn_raw       = b;
    pause         = p;
    core_end_game = e;
    core_score    = s;
  endtask

  // One clock cycle: drive, predict, check mid-cycle, then advance the model
  task automatic runCycle(input logic r, input logic b, input logic p,
                          input logic e, input logic [SCORE_W-1:0] s);
    bit pulse, pausedEff, tickNow, timeoutCond;
    bit expTimeout, expEnable, expBin, expActive;
    int remaining, expTime;

    applyStimulus(r, b, p, e, s);

    pulse = b && !mBtnPrev;
`ifdef PAUSE_ACTIVE_EN
    pausedEff = p && (mPhase == M_PLAY);
`else
    pausedEff = 1'b0;
`endif
    remaining   = SESSION_SEC - (mActive / CLK_HZ);
    tickNow     = (mPhase == M_PLAY) && !pausedEff && (((mActive + 1) % CLK_HZ) == 0);
    timeoutCond = tickNow && (remaining == 1);
    expTimeout  = !r && timeoutCond && !e;
    expEnable   = !r && ((mPhase == M_ARM) || (mPhase == M_WAIT) ||
                         ((mPhase == M_PLAY) && !pausedEff));
    expBin      = !r && ((mPhase == M_ARM) || ((mPhase == M_PLAY) && !pausedEff && pulse));
    expActive   = !r && ((mPhase == M_ARM) || (mPhase == M_PLAY) || (mPhase == M_WAIT));
    expTime     = mTimeValid ? remaining : 0;

    #4;
    checkOutput("core_rst_n",     32'(core_rst_n),     32'(!r && (mPhase != M_CLEAR)));
    checkOutput("core_enable",    32'(core_enable),    32'(expEnable));
    checkOutput("core_bIn",       32'(core_bIn),       32'(expBin));
    checkOutput("game_timeout",   32'(game_timeout),   32'(expTimeout));
    checkOutput("session_active", 32'(session_active), 32'(expActive));
    checkOutput("time_left",      32'(time_left),      32'(expTime));
    checkOutput("last_score",     32'(last_score),     32'(mLast));
    checkOutput("best_score",     32'(best_score),     32'(mBest));
    checkOutput("timeout_twice",  32'(game_timeout && prevTimeout), 32'd0);
    prevTimeout = game_timeout;

    @(posedge clk);
    if (r) begin
      mPhase     = M_IDLE;
      mBtnPrev   = 1'b0;
      mTimeValid = 1'b0;
      mActive    = 0;
      mWait      = 0;
      mLast      = 0;
      mBest      = 0;
    end else begin
      mBtnPrev = b;
      case (mPhase)
        M_IDLE, M_DONE: if (pulse) mPhase = M_CLEAR;
        M_CLEAR: begin
          mActive    = 0;
          mTimeValid = 1'b1;
          mPhase     = M_ARM;
        end
        M_ARM: mPhase = M_PLAY;
        M_PLAY: begin
          if (!pausedEff) mActive++;
          if (e || timeoutCond) begin
            mWait  = 0;
            mPhase = M_WAIT;
          end
        end
        M_WAIT: begin
          if (e || (mWait == WAIT_MAX)) begin
            mLast = int'(s);
            if (int'(s) > mBest) mBest = int'(s);
            mPhase = M_DONE;
          end else begin
            mWait++;
          end
        end
        default: mPhase = M_IDLE;
      endcase
    end
    #1;
  endtask

  initial begin
    logic r, b, p, e;
    $display("[TB] game_session_ctrl bench start");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) runCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Session 1: press and hold, timeout in the 12th PLAY cycle
    for (int i = 1; i <= 15; i++) begin
      runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
      checkOutput("timeout_slot", 32'(prevTimeout), 32'(i == 15));
    end
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    runCycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("s1_last", 32'(last_score), 32'd5);
    checkOutput("s1_best", 32'(best_score), 32'd5);

    // Session 2: early end with score 3, best stays at 5
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    runCycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    runCycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("s2_last", 32'(last_score), 32'd3);
    checkOutput("s2_best", 32'(best_score), 32'd5);

    // Session 3: core never ends, guard expires after 8 WAIT_END cycles
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 22; i++) runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
    checkOutput("s3_waiting", 32'(session_active), 32'd1);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
    checkOutput("s3_done", 32'(session_active), 32'd0);
    checkOutput("s3_last", 32'(last_score), 32'd9);
    checkOutput("s3_best", 32'(best_score), 32'd9);

    // Session 4: reset pulse mid-PLAY drops everything, nothing captured
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    runCycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd12);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    checkOutput("s4_best", 32'(best_score), 32'd0);
    checkOutput("s4_last", 32'(last_score), 32'd0);
    checkOutput("s4_idle", 32'(session_active), 32'd0);

    // Session 5: pause for 10 cycles inside PLAY
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++)  runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 10; i++) runCycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
    for (int i = 0; i < 30; i++) runCycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);

    // Randomized traffic
    r = 1'b0; b = 1'b0; p = 1'b0; e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) b = ~b;
      if ($urandom_range(0, 5) == 0) p = ~p;
      e = ($urandom_range(0, 24) == 0);
      runCycle(r, b, p, e, SCORE_W'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_game_session_ctrl
